// File: rtl/video_timing_generator.sv
// Raster timing generator: h/v counters, registered lead outputs for the pattern
// generator, and sync/de re-timed by DATA_LATENCY enabled cycles.
module video_timing_generator #(
    parameter int ROW_ADDR_WIDTH = 10,
    parameter int COL_ADDR_WIDTH = 11,
    parameter int CNT_WIDTH      = 11,
    parameter int H_ACTIVE       = 1280,
    parameter int H_FP           = 48,
    parameter int H_SYNC         = 112,
    parameter int H_BP           = 248,
    parameter int V_ACTIVE       = 1024,
    parameter int V_FP           = 1,
    parameter int V_SYNC         = 3,
    parameter int V_BP           = 38,
    parameter bit H_POL          = 1'b1,
    parameter bit V_POL          = 1'b1,
    parameter int DATA_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic [ROW_ADDR_WIDTH-1:0] row_address,
    output logic [COL_ADDR_WIDTH-1:0] col_address,
    output logic                      next_pixel,
    output logic                      frame_start,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive bounds so that no constant needs to hold H_TOTAL itself.
    localparam logic [CNT_WIDTH-1:0] C_H_LAST     = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] C_V_LAST     = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] C_H_ACT_LAST = CNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] C_V_ACT_LAST = CNT_WIDTH'(V_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] C_HS_FIRST   = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] C_HS_LAST    = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_WIDTH-1:0] C_VS_FIRST   = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] C_VS_LAST    = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic HS_IDLE = ~H_POL;
    localparam logic VS_IDLE = ~V_POL;

    logic [CNT_WIDTH-1:0]      r_h_cnt;
    logic [CNT_WIDTH-1:0]      r_v_cnt;
    logic [ROW_ADDR_WIDTH-1:0] r_row;
    logic [COL_ADDR_WIDTH-1:0] r_col;
    logic                      r_next_pixel;
    logic                      r_frame_start;
    logic                      r_hs_pipe [0:DATA_LATENCY];
    logic                      r_vs_pipe [0:DATA_LATENCY];
    logic                      r_de_pipe [0:DATA_LATENCY];

    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_origin;

    assign w_active = (r_h_cnt <= C_H_ACT_LAST) && (r_v_cnt <= C_V_ACT_LAST);
    assign w_hs     = (r_h_cnt >= C_HS_FIRST) && (r_h_cnt <= C_HS_LAST);
    assign w_vs     = (r_v_cnt >= C_VS_FIRST) && (r_v_cnt <= C_VS_LAST);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (enable) begin
            if (r_h_cnt == C_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + CNT_WIDTH'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Lead outputs and delay stage 0 both capture the pre-increment position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row         <= '0;
            r_col         <= '0;
            r_next_pixel  <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs_pipe[0]  <= HS_IDLE;
            r_vs_pipe[0]  <= VS_IDLE;
            r_de_pipe[0]  <= 1'b0;
        end else if (enable) begin
            r_row         <= w_active ? ROW_ADDR_WIDTH'(r_v_cnt) : '0;
            r_col         <= w_active ? COL_ADDR_WIDTH'(r_h_cnt) : '0;
            r_next_pixel  <= w_active;
            r_frame_start <= w_origin;
            r_hs_pipe[0]  <= w_hs ? H_POL : HS_IDLE;
            r_vs_pipe[0]  <= w_vs ? V_POL : VS_IDLE;
            r_de_pipe[0]  <= w_active;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= DATA_LATENCY; gi++) begin : g_delay
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hs_pipe[gi] <= HS_IDLE;
                    r_vs_pipe[gi] <= VS_IDLE;
                    r_de_pipe[gi] <= 1'b0;
                end else if (enable) begin
                    r_hs_pipe[gi] <= r_hs_pipe[gi-1];
                    r_vs_pipe[gi] <= r_vs_pipe[gi-1];
                    r_de_pipe[gi] <= r_de_pipe[gi-1];
                end
            end
        end
    endgenerate

    assign row_address = r_row;
    assign col_address = r_col;
    assign next_pixel  = r_next_pixel;
    assign frame_start = r_frame_start;
    assign hsync       = r_hs_pipe[DATA_LATENCY];
    assign vsync       = r_vs_pipe[DATA_LATENCY];
    assign de          = r_de_pipe[DATA_LATENCY];
endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Produces raster timing for the HDMI output path: pixel position, pixel request strobe, and hsync/vsync/de.
- Drives video_pattern_generator through row_address, col_address and next_pixel.
- Re-times hsync/vsync/de by DATA_LATENCY cycles so they line up with the registered pixel data at the encoder input.
- Defaults are 1280x1024@60, 108 MHz pixel clock.

Parameters:
- ROW_ADDR_WIDTH, 10, width of row_address
- COL_ADDR_WIDTH, 11, width of col_address
- CNT_WIDTH, 11, width of internal h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch
- H_SYNC, 112, hsync width
- H_BP, 248, horizontal back porch; H_TOTAL = sum of the four = 1688
- V_ACTIVE, 1024, active lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 38, vertical back porch; V_TOTAL = 1066
- H_POL, 1, hsync active level
- V_POL, 1, vsync active level
- DATA_LATENCY, 1, extra cycles on hsync/vsync/de relative to the lead outputs; range 0..7

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  advance raster when high; freeze everything when low
- row_address  output  ROW_ADDR_WIDTH  active line index, 0 outside active area
- col_address  output  COL_ADDR_WIDTH  active pixel index, 0 outside active area
- next_pixel  output  1  high when current position is active (lead)
- frame_start  output  1  one-cycle pulse at position (0,0) (lead)
- hsync  output  1  horizontal sync, delayed DATA_LATENCY
- vsync  output  1  vertical sync, delayed DATA_LATENCY
- de  output  1  data enable, delayed DATA_LATENCY

Behaviour:
- Counters
  - Internal h_cnt and v_cnt are registered and reset to 0.
  - On each enabled edge h_cnt increments.
  - At h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 together with the h wrap, v_cnt wraps to 0.
- Decode of position (h,v)
  - active = h < H_ACTIVE && v < V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vs is line-based, so it changes only at h=0.
- Lead outputs (all registered)
  - On each enabled edge they load the decode of the pre-increment counters.
  - A position is therefore visible one cycle after the edge that consumes it.
  - row_address/col_address = v/h when active, else 0. Truncate to port width; active values always fit.
  - This guarantees row==V_ACTIVE-1 && col==H_ACTIVE-1 is true for exactly one cycle per frame. video_pattern_generator's frame-advance depends on this.
  - next_pixel = active.
  - frame_start = (h==0 && v==0).
- Delayed outputs
  - hsync = hs ? H_POL : ~H_POL. vsync is formed the same way from vs and V_POL. de = active.
  - These pass through a DATA_LATENCY-stage shift register, advanced only on enabled edges.
  - With DATA_LATENCY=0 they are coincident with the lead outputs.
- Reset
  - Counters go to 0 and lead outputs to 0; frame_start = 0.
  - hsync = ~H_POL, vsync = ~V_POL, de = 0.
  - All delay stages are cleared to the same idle values.
  - Reset mid-frame aborts the frame immediately. The next frame restarts at (0,0) with no partial-line completion.
- enable low
  - Counters, all output registers and delay stages hold their values.
  - Outputs stay static, not forced idle.
  - Resume continues from the held position with no skipped or repeated position.
- Precedence: rst overrides enable.
- Period and timing checks
  - One frame is exactly H_TOTAL*V_TOTAL enabled cycles.
  - Per active line, next_pixel is high for exactly H_ACTIVE consecutive enabled cycles.

Test Plan:
- Small-raster parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), DATA_LATENCY=1.
  - Release rst with enable=1 -> frame_start=1 exactly one cycle after the first edge, with next_pixel=1 and row=0, col=0.
  - frame_start repeats every 98 cycles.
  - de rises one cycle after next_pixel.
- Small raster, one full line -> next_pixel high 8 cycles with col 0..7, then 6 cycles low with col=0.
  - hsync high for 2 cycles, starting 10 cycles after col=0, plus 1 cycle of DATA_LATENCY delay.
- Small raster, one full frame -> vsync high for exactly 14 cycles on line 5.
  - row=3 && col=7 occurs exactly once per frame.
  - de high for 32 cycles per frame.
- Default 1280x1024 -> frame_start period 1799408 cycles.
  - Per frame: hsync pulse 112 cycles, 1066 hsync pulses, vsync 3 lines = 5064 cycles.
  - last-pixel match (row 1023, col 1279) once.
- Mid-frame events at position (5,2):
  - enable low for 20 cycles -> all outputs frozen; sequence resumes at (6,2).
  - Assert rst there -> next frame_start one cycle after release; all delayed outputs show idle values during reset.
- H_POL=0, V_POL=0, DATA_LATENCY=3 -> syncs idle high and pulse low.
  - hsync/vsync/de lag the lead decode by exactly 3 enabled cycles, including across an enable gap.
